instr_fetch_unit: RTL and testbench

- Holds the architectural PC and fetches each instruction from instruction memory over a req/ack handshake.
- Presents the current PC as Address to the next-PC logic and the fetched word as Instr to the decoder.
- Loads NPC from the next-PC logic when the core retires the instruction.
- Turns the single-cycle datapath into a multi-cycle-tolerant front end. Memory latency and core stalls are absorbed here.

---
 rtl/cpu_defs.sv | 23 ++
 rtl/pc_range_check.sv | 28 ++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared front-end definitions: reset/memory-map constants, fetch FSM encoding
// and fetch error cause codes.
package cpu_defs;

    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_BASE     = 32'h0000_3000;
    localparam int          DEF_IM_WORDS    = 1024;
    localparam int          DEF_ACK_TIMEOUT = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_ERROR = 3'd4
    } fetch_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/pc_range_check.sv
// Combinational word-alignment and window test for a byte address.
// Returns ERR_NONE, ERR_ALIGN or ERR_RANGE; alignment wins when both apply.
module pc_range_check
    import cpu_defs::*;
#(
    parameter logic [31:0] BASE  = DEF_IM_BASE,
    parameter int          WORDS = DEF_IM_WORDS
) (
    input  logic [31:0] pc,
    output logic [1:0]  cause
);

    // 33-bit limit so a window reaching the top of the address space still fits
    localparam logic [32:0] LIMIT = 33'(WORDS) << 2;

    logic [31:0] offset;

    always_comb begin
        offset = pc - BASE;
        cause  = ERR_NONE;
        if (pc[1:0] != 2'b00) begin
            cause = ERR_ALIGN;
        end else if ((pc < BASE) || ({1'b0, offset} >= LIMIT)) begin
            cause = ERR_RANGE;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over a req/ack handshake,
// holds the word until the core retires it, and latches a sticky fetch error.
module instr_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [31:0] IM_BASE     = DEF_IM_BASE,
    parameter int          IM_WORDS    = DEF_IM_WORDS,
    parameter int          ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    localparam int         AW          = $clog2(IM_WORDS)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [31:0]   NPC,
    input  logic          Instr_Ready,
    input  logic          Flush,
    output logic          IM_Req,
    output logic [AW-1:0] IM_Addr,
    input  logic          IM_Ack,
    input  logic [31:0]   IM_Data,
    output logic [31:0]   Address,
    output logic [31:0]   Instr,
    output logic          Instr_Valid,
    output logic          Fetch_Err,
    output logic [1:0]    Err_Cause
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    fetch_state_t  state, state_nx;
    logic [31:0]   pc, pc_nx;
    logic [31:0]   instr, instr_nx;
    logic          valid, valid_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          err, err_nx;
    logic [1:0]    cause, cause_nx;
    logic [1:0]    chk_cause;

    pc_range_check #(
        .BASE  (IM_BASE),
        .WORDS (IM_WORDS)
    ) u_pc_check (
        .pc    (pc),
        .cause (chk_cause)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= '0;
            valid <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
            cause <= ERR_NONE;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            instr <= instr_nx;
            valid <= valid_nx;
            cnt   <= cnt_nx;
            err   <= err_nx;
            cause <= cause_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = instr;
        valid_nx = valid;
        cnt_nx   = cnt;
        err_nx   = err;
        cause_nx = cause;
        case (state)
            S_IDLE: state_nx = S_CHECK;
            S_CHECK: begin
                cnt_nx = '0;
                if (chk_cause != ERR_NONE) begin
                    state_nx = S_ERROR;
                    err_nx   = 1'b1;
                    cause_nx = chk_cause;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                // Flush beats a same-cycle ack: the returning word is dropped
                if (Flush) begin
                    pc_nx    = NPC;
                    valid_nx = 1'b0;
                    cnt_nx   = '0;
                    state_nx = S_CHECK;
                end else if (IM_Ack) begin
                    instr_nx = IM_Data;
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_VALID;
                end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                    err_nx   = 1'b1;
                    cause_nx = ERR_TIMEOUT;
                    cnt_nx   = '0;
                    state_nx = S_ERROR;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_VALID: begin
                if (Flush || Instr_Ready) begin
                    pc_nx    = NPC;
                    valid_nx = 1'b0;
                    state_nx = S_CHECK;
                end
            end
            S_ERROR: valid_nx = 1'b0;
            default: state_nx = S_IDLE;
        endcase
    end

    assign IM_Req      = (state == S_WAIT);
    assign IM_Addr     = AW'((pc - IM_BASE) >> 2);
    assign Address     = pc;
    assign Instr       = instr;
    assign Instr_Valid = valid;
    assign Fetch_Err   = err;
    assign Err_Cause   = cause;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: each task drives one scenario and
// compares outputs against hand-derived values.
module tb_instr_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] NPC;
    logic        Instr_Ready;
    logic        Flush;
    logic        IM_Req;
    logic [9:0]  IM_Addr;
    logic        IM_Ack;
    logic [31:0] IM_Data;
    logic [31:0] Address;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic        Fetch_Err;
    logic [1:0]  Err_Cause;

    int tests = 0;
    int fails = 0;

    instr_fetch_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .NPC         (NPC),
        .Instr_Ready (Instr_Ready),
        .Flush       (Flush),
        .IM_Req      (IM_Req),
        .IM_Addr     (IM_Addr),
        .IM_Ack      (IM_Ack),
        .IM_Data     (IM_Data),
        .Address     (Address),
        .Instr       (Instr),
        .Instr_Valid (Instr_Valid),
        .Fetch_Err   (Fetch_Err),
        .Err_Cause   (Err_Cause)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Leaves the DUT in IDLE, sampled one unit after a clock edge
    task automatic apply_reset();
        Reset = 1'b0; NPC = '0; Instr_Ready = 1'b0; Flush = 1'b0;
        IM_Ack = 1'b0; IM_Data = '0;
        tick();
        Reset = 1'b1;
    endtask

    // From IDLE: CHECK, WAIT with a zero-wait ack, then VALID
    task automatic goto_valid(input logic [31:0] data);
        tick();
        tick();
        IM_Ack = 1'b1; IM_Data = data;
        tick();
        IM_Ack = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; NPC = '0; Instr_Ready = 1'b0; Flush = 1'b0;
        IM_Ack = 1'b0; IM_Data = '0;
        #2 Reset = 1'b0;
        #1;
        tests++; if (Address !== 32'h3000) begin fails++; $display("FAIL reset_addr got %h exp %h", Address, 32'h3000); end
        tests++; if (Instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 0", Instr); end
        tests++; if (Instr_Valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", Instr_Valid); end
        tests++; if (IM_Req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", IM_Req); end
        tests++; if (Fetch_Err !== 1'b0 || Err_Cause !== 2'b00) begin fails++; $display("FAIL reset_err got %b/%b exp 0/00", Fetch_Err, Err_Cause); end
    endtask

    task automatic test_sequential();
        int phase, idx, vcount;
        vcount = 0;
        apply_reset();
        Instr_Ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            NPC = Address + 32'd4;
            IM_Ack = IM_Req;
            IM_Data = 32'hA500_0000 | 32'(IM_Addr);
            phase = (k - 1) % 3;
            idx = (k - 1) / 3;
            if (Instr_Valid === 1'b1) vcount++;
            tests++; if (Address !== 32'h3000 + 32'(4 * idx)) begin fails++; $display("FAIL seq_addr k=%0d got %h exp %h", k, Address, 32'h3000 + 32'(4 * idx)); end
            tests++; if (IM_Req !== (phase == 1)) begin fails++; $display("FAIL seq_req k=%0d got %b exp %b", k, IM_Req, phase == 1); end
            tests++; if (Instr_Valid !== (phase == 2)) begin fails++; $display("FAIL seq_valid k=%0d got %b exp %b", k, Instr_Valid, phase == 2); end
            if (phase == 1) begin
                tests++; if (IM_Addr !== 10'(idx)) begin fails++; $display("FAIL seq_imaddr k=%0d got %h exp %h", k, IM_Addr, 10'(idx)); end
            end
            if (phase == 2) begin
                tests++; if (Instr !== 32'hA500_0000 + 32'(idx)) begin fails++; $display("FAIL seq_instr k=%0d got %h exp %h", k, Instr, 32'hA500_0000 + 32'(idx)); end
            end
        end
        tests++; if (vcount !== 3) begin fails++; $display("FAIL seq_valid_count got %0d exp 3", vcount); end
        Instr_Ready = 1'b0; IM_Ack = 1'b0;
    endtask

    task automatic test_delayed_ack();
        apply_reset();
        NPC = 32'h0000_5550;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++; if (IM_Req !== 1'b1 || IM_Addr !== 10'h000) begin fails++; $display("FAIL dly_req i=%0d got %b/%h exp 1/000", i, IM_Req, IM_Addr); end
            tests++; if (Instr_Valid !== 1'b0) begin fails++; $display("FAIL dly_valid_early i=%0d got %b exp 0", i, Instr_Valid); end
            if (i < 4) tick();
        end
        IM_Ack = 1'b1; IM_Data = 32'h2010_0005;
        tick();
        IM_Ack = 1'b0;
        tests++; if (Instr !== 32'h2010_0005 || Instr_Valid !== 1'b1) begin fails++; $display("FAIL dly_instr got %h/%b exp 20100005/1", Instr, Instr_Valid); end
        tests++; if (IM_Req !== 1'b0) begin fails++; $display("FAIL dly_req_drop got %b exp 0", IM_Req); end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (Address !== 32'h3000 || Instr_Valid !== 1'b1) begin fails++; $display("FAIL dly_hold i=%0d got %h/%b exp 00003000/1", i, Address, Instr_Valid); end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        goto_valid(32'h1111_2222);
        NPC = 32'h3333_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (Instr !== 32'h1111_2222 || Instr_Valid !== 1'b1) begin fails++; $display("FAIL stall_instr i=%0d got %h/%b exp 11112222/1", i, Instr, Instr_Valid); end
            tests++; if (Address !== 32'h3000) begin fails++; $display("FAIL stall_addr i=%0d got %h exp 00003000", i, Address); end
        end
        NPC = 32'h3040; Instr_Ready = 1'b1;
        tick();
        Instr_Ready = 1'b0;
        tests++; if (Address !== 32'h3040 || Instr_Valid !== 1'b0) begin fails++; $display("FAIL stall_retire got %h/%b exp 00003040/0", Address, Instr_Valid); end
        tick();
        tests++; if (IM_Req !== 1'b1 || IM_Addr !== 10'h010) begin fails++; $display("FAIL stall_next got %b/%h exp 1/010", IM_Req, IM_Addr); end
    endtask

    task automatic test_flush();
        apply_reset();
        tick();
        tick();
        Flush = 1'b1; NPC = 32'h3100; IM_Ack = 1'b1; IM_Data = 32'hDEAD_BEEF;
        tick();
        Flush = 1'b0; IM_Ack = 1'b0;
        tests++; if (Instr_Valid !== 1'b0 || Instr !== 32'h0) begin fails++; $display("FAIL flush_drop got %h/%b exp 00000000/0", Instr, Instr_Valid); end
        tests++; if (Address !== 32'h3100 || IM_Req !== 1'b0) begin fails++; $display("FAIL flush_pc got %h/%b exp 00003100/0", Address, IM_Req); end
        tick();
        tests++; if (IM_Req !== 1'b1 || IM_Addr !== 10'h040) begin fails++; $display("FAIL flush_next got %b/%h exp 1/040", IM_Req, IM_Addr); end
        IM_Ack = 1'b1; IM_Data = 32'h0BAD_F00D;
        tick();
        IM_Ack = 1'b0;
        Flush = 1'b1; NPC = 32'h3200;
        tick();
        Flush = 1'b0;
        tests++; if (Instr_Valid !== 1'b0 || Address !== 32'h3200) begin fails++; $display("FAIL flush_valid got %h/%b exp 00003200/0", Address, Instr_Valid); end
    endtask

    task automatic test_errors();
        logic [31:0] npcs  [6] = '{32'h3002, 32'h2FFC, 32'h4000, 32'hFFFF_FFFC, 32'h3FFC, 32'h3001};
        logic [1:0]  codes [6] = '{2'b01,    2'b10,    2'b10,    2'b10,         2'b00,    2'b01};
        logic [9:0]  ok_addr;
        ok_addr = 10'h3FF;
        for (int t = 0; t < 6; t++) begin
            apply_reset();
            goto_valid(32'h0000_0013);
            NPC = npcs[t]; Instr_Ready = 1'b1;
            tick();
            Instr_Ready = 1'b0;
            tests++; if (Address !== npcs[t]) begin fails++; $display("FAIL err_pc t=%0d got %h exp %h", t, Address, npcs[t]); end
            tick();
            if (codes[t] == 2'b00) begin
                tests++; if (IM_Req !== 1'b1 || IM_Addr !== ok_addr || Fetch_Err !== 1'b0) begin fails++; $display("FAIL err_edge_ok t=%0d got %b/%h/%b exp 1/%h/0", t, IM_Req, IM_Addr, Fetch_Err, ok_addr); end
            end else begin
                tests++; if (Fetch_Err !== 1'b1 || Err_Cause !== codes[t]) begin fails++; $display("FAIL err_cause t=%0d got %b/%b exp 1/%b", t, Fetch_Err, Err_Cause, codes[t]); end
                Flush = 1'b1; Instr_Ready = 1'b1; IM_Ack = 1'b1; NPC = 32'h3000;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    tests++; if (IM_Req !== 1'b0 || Instr_Valid !== 1'b0 || Fetch_Err !== 1'b1 || Err_Cause !== codes[t]) begin fails++; $display("FAIL err_sticky t=%0d i=%0d got req=%b v=%b e=%b c=%b exp 0/0/1/%b", t, i, IM_Req, Instr_Valid, Fetch_Err, Err_Cause, codes[t]); end
                end
                apply_reset();
                tests++; if (Fetch_Err !== 1'b0 || Err_Cause !== 2'b00) begin fails++; $display("FAIL err_clear t=%0d got %b/%b exp 0/00", t, Fetch_Err, Err_Cause); end
            end
        end
        Flush = 1'b0; Instr_Ready = 1'b0; IM_Ack = 1'b0;
    endtask

    task automatic test_timeout();
        apply_reset();
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tests++; if (IM_Req !== 1'b1 || Fetch_Err !== 1'b0) begin fails++; $display("FAIL tmo_wait i=%0d got %b/%b exp 1/0", i, IM_Req, Fetch_Err); end
            tick();
        end
        tests++; if (Fetch_Err !== 1'b1 || Err_Cause !== 2'b11 || IM_Req !== 1'b0) begin fails++; $display("FAIL tmo_err got %b/%b/%b exp 1/11/0", Fetch_Err, Err_Cause, IM_Req); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        Instr_Ready = 1'b1;
        goto_valid(32'h7777_0001);
        NPC = 32'h3010;
        tick();
        Instr_Ready = 1'b0;
        tick();
        tests++; if (Address !== 32'h3010 || IM_Req !== 1'b1) begin fails++; $display("FAIL rmw_pre got %h/%b exp 00003010/1", Address, IM_Req); end
        #2 Reset = 1'b0;
        #1;
        tests++; if (Address !== 32'h3000 || IM_Req !== 1'b0 || Instr !== 32'h0) begin fails++; $display("FAIL rmw_async got %h/%b/%h exp 00003000/0/00000000", Address, IM_Req, Instr); end
        IM_Ack = 1'b1; IM_Data = 32'hBAD0_BAD0;
        tick();
        Reset = 1'b1;
        tick();
        IM_Ack = 1'b0;
        tests++; if (Instr_Valid !== 1'b0 || Instr !== 32'h0) begin fails++; $display("FAIL rmw_late_ack got %h/%b exp 00000000/0", Instr, Instr_Valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_stall();
        test_flush();
        test_errors();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
